// File: rtl/char_seq_gen_pkg.sv
// ----------------------------------------------------------------------------
// chargen_pkg
// Shared types and helpers for the ASCII character sequencer and for anything
// that consumes its stream (for example a FIFO-side checker).
//   char_t    : one 8-bit character code
//   CH_A/C/Z  : ASCII constants "a", "c", "z"
//   char_next : pure next-character function with wrap and out-of-range
//               recovery; the sequencer and a checker can share it
// ----------------------------------------------------------------------------
package chargen_pkg;

    typedef logic [7:0] char_t;

    localparam char_t CH_A = 8'h61;
    localparam char_t CH_C = 8'h63;
    localparam char_t CH_Z = 8'h7A;

    // Step one character forward inside [first, last].
    // A value already outside the window, which can only happen if the
    // register was never reset, restarts at 'first' rather than wandering
    // through unrelated codes.
    function automatic char_t char_next(char_t c, char_t first, char_t last);
        char_t result;
        result = c + 8'd1;
        if (c == last) begin
            result = first;
        end else if ((c < first) || (c > last)) begin
            result = first;
        end
        return result;
    endfunction

endpackage

// File: rtl/char_seq_gen_if.sv
// ----------------------------------------------------------------------------
// char_seq_gen_if
// Byte-producer bus between the character sequencer and its user.
//   n_cs : chip select, active-low; advances the sequence each clock
//   n_wr : write strobe, active-low; restarts the sequence only in builds
//          with CHARGEN_RELOAD_EN defined
//   port : current character, registered inside the sequencer
// Modports: master drives n_cs/n_wr and reads port; slave is the sequencer.
// ----------------------------------------------------------------------------
interface char_seq_gen_if;
    import chargen_pkg::*;

    logic  n_cs;
    logic  n_wr;
    char_t port;

    modport master (output n_cs, output n_wr, input  port);
    modport slave  (input  n_cs, input  n_wr, output port);

endinterface

// File: rtl/char_seq_gen.sv
// ----------------------------------------------------------------------------
// char_seq_gen
// Synchronous ASCII test-pattern sequencer. Each clock with chip select low
// presents the next code of FIRSTCHAR..LASTCHAR on 'port', wrapping from
// LASTCHAR back to FIRSTCHAR in a single step.
// Ports:
//   clk   : system clock, rising-edge active
//   n_rst : synchronous active-low reset, loads FIRSTCHAR
//   bus   : char_seq_gen_if.slave (n_cs, n_wr in; port out)
// Parameters:
//   FIRSTCHAR : reset value and wrap target (default "a")
//   LASTCHAR  : final code before wrapping (default "z")
// Build option:
//   CHARGEN_RELOAD_EN : when defined, n_cs low together with n_wr low
//                       restarts the sequence at FIRSTCHAR, ahead of advance.
//                       When undefined, n_wr is ignored.
// ----------------------------------------------------------------------------
module char_seq_gen
    import chargen_pkg::*;
#(
    parameter char_t FIRSTCHAR = CH_A,
    parameter char_t LASTCHAR  = CH_Z
) (
    input  logic          clk,
    input  logic          n_rst,
    char_seq_gen_if.slave bus
);

    // An inverted window has no meaningful sequence, so refuse to elaborate.
    if (FIRSTCHAR > LASTCHAR) begin : g_bad_range
        $error("char_seq_gen: FIRSTCHAR must not exceed LASTCHAR");
    end

    char_t port_q;
    char_t port_d;

`ifdef CHARGEN_RELOAD_EN
    logic reload;
    // Restart request: both strobes low. Written as explicit comparisons so
    // an unknown strobe does not count as a request.
    assign reload = (bus.n_cs == 1'b0) && (bus.n_wr == 1'b0);
`else
    logic unused_wr;
    assign unused_wr = bus.n_wr;
`endif

    // Next-state selection in priority order: reset, reload, advance, hold.
    // Advance is gated on "!n_cs" so an unknown select holds the character.
    always_comb begin
        port_d = port_q;
        if (!n_rst) begin
            port_d = FIRSTCHAR;
`ifdef CHARGEN_RELOAD_EN
        end else if (reload) begin
            port_d = FIRSTCHAR;
`endif
        end else if (!bus.n_cs) begin
            port_d = char_next(port_q, FIRSTCHAR, LASTCHAR);
        end
    end

    // Single character register; reset is folded into port_d so it only
    // acts on the rising edge.
    always_ff @(posedge clk) begin
        port_q <= port_d;
    end

    assign bus.port = port_q;

endmodule

// File: tb/tb_char_seq_gen.sv
// ----------------------------------------------------------------------------
// tb_char_seq_gen
// Directed bench for char_seq_gen. Three instances share one clock:
//   dutC : window "a".."c" (short wrap, hold, reset priority, reload)
//   dutZ : default window "a".."z" (full alphabet and wrap)
//   dutE : FIRSTCHAR == LASTCHAR == "a" (degenerate window stays constant)
// ----------------------------------------------------------------------------
module tb_char_seq_gen;
    import chargen_pkg::*;

    logic clk;
    logic nRstC;
    logic nRstZ;

    int numCompared   = 0;
    int numMismatched = 0;

    char_seq_gen_if ifC ();
    char_seq_gen_if ifZ ();
    char_seq_gen_if ifE ();

    char_seq_gen #(.FIRSTCHAR(CH_A), .LASTCHAR(CH_C)) dutC (
        .clk   (clk),
        .n_rst (nRstC),
        .bus   (ifC)
    );

    char_seq_gen dutZ (
        .clk   (clk),
        .n_rst (nRstZ),
        .bus   (ifZ)
    );

    char_seq_gen #(.FIRSTCHAR(CH_A), .LASTCHAR(CH_A)) dutE (
        .clk   (clk),
        .n_rst (nRstZ),
        .bus   (ifE)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log mismatches.
    task automatic checkOutput(input string tag, input char_t observed, input char_t expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed 8'h%02h, expected 8'h%02h", tag, observed, expected);
        end
    endtask

    // Drive the short-window instance, then let one rising edge pass and
    // settle 1 unit after it so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic nRst, input logic nCs, input logic nWr);
        nRstC    = nRst;
        ifC.n_cs = nCs;
        ifC.n_wr = nWr;
        @(posedge clk);
        #1;
    endtask

    // Same for the default-window and degenerate-window instances together.
    task automatic applyLongStimulus(input logic nRst, input logic nCs);
        nRstZ    = nRst;
        ifZ.n_cs = nCs;
        ifZ.n_wr = 1'b1;
        ifE.n_cs = nCs;
        ifE.n_wr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        char_t expC;
        logic  xAdvanced;

        nRstC    = 1'b1;
        ifC.n_cs = 1'bx;
        ifC.n_wr = 1'b1;
        nRstZ    = 1'b1;
        ifZ.n_cs = 1'b1;
        ifZ.n_wr = 1'b1;
        ifE.n_cs = 1'b1;
        ifE.n_wr = 1'b1;

        // Reset pulse with chip select left unknown.
        applyStimulus(1'b1, 1'bx, 1'b1);
        applyStimulus(1'b0, 1'bx, 1'b1);
        checkOutput("reset_state", ifC.port, 8'h61);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("post_reset_hold", ifC.port, 8'h61);

        // Five advances across the c->a wrap: b, c, a, b, c.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("adv1_b", ifC.port, 8'h62);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("adv2_c", ifC.port, 8'h63);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("adv3_wrap_a", ifC.port, 8'h61);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("adv4_b", ifC.port, 8'h62);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("adv5_c", ifC.port, 8'h63);

        // Two more steps land on "b" for the hold tests.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("to_b", ifC.port, 8'h62);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput($sformatf("hold%0d_b", i), ifC.port, 8'h62);
        end

        // Unknown select must hold. A two-state simulator turns the X into a
        // concrete level, so expect an advance only if the bench's own drive
        // actually reads as 0.
        nRstC    = 1'b1;
        ifC.n_cs = 1'bx;
        ifC.n_wr = 1'b1;
        xAdvanced = (ifC.n_cs === 1'b0);
        @(posedge clk);
        #1;
        expC = xAdvanced ? 8'h63 : 8'h62;
        checkOutput("hold_x_cs", ifC.port, expC);

        // Return to "b" if the step above advanced, then reset against advance.
        if (xAdvanced) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        checkOutput("before_rst_b", ifC.port, 8'h62);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_beats_adv", ifC.port, 8'h61);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("release_adv_b", ifC.port, 8'h62);

        // Write strobe with select: restart in reload builds, plain advance otherwise.
        applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef CHARGEN_RELOAD_EN
        checkOutput("reload_wr", ifC.port, 8'h61);
`else
        checkOutput("reload_wr", ifC.port, 8'h63);
`endif

        // Write strobe alone (select high) never changes the character.
        applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef CHARGEN_RELOAD_EN
        checkOutput("wr_no_cs_hold", ifC.port, 8'h61);
`else
        checkOutput("wr_no_cs_hold", ifC.port, 8'h63);
`endif

        // Full alphabet: step k shows "a"+k up to "z", then wraps to "a".
        applyLongStimulus(1'b0, 1'b1);
        checkOutput("z_reset", ifZ.port, 8'h61);
        checkOutput("e_reset", ifE.port, 8'h61);
        for (int k = 1; k <= 26; k++) begin
            applyLongStimulus(1'b1, 1'b0);
            if (k <= 25) begin
                checkOutput($sformatf("z_step%0d", k), ifZ.port, 8'h61 + 8'(k));
            end else begin
                checkOutput("z_wrap_a", ifZ.port, 8'h61);
            end
            checkOutput($sformatf("e_step%0d", k), ifE.port, 8'h61);
        end

        // Out-of-window recovery of the shared next-character function.
        checkOutput("fn_below", char_next(8'h10, CH_A, CH_C), 8'h61);
        checkOutput("fn_above", char_next(8'h70, CH_A, CH_C), 8'h61);
        checkOutput("fn_step", char_next(8'h62, CH_A, CH_C), 8'h63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
